// File: rtl/signed_seq_mult_ctrl_pkg.sv
// ============================================================================
//  Module      : signed_seq_mult_ctrl_pkg
//  Description : Shared definitions for the sequential signed multiplier
//                controller: state encoding, shared-negator select codes,
//                default operand width and the state-to-select mapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package signed_seq_mult_ctrl_pkg;

    localparam int C_DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_MUL    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Which operand the single shared negator is working on.
    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SEL_B  = 2'd1,
        SEL_LO = 2'd2,
        SEL_HI = 2'd3
    } neg_sel_t;

    // Negator select required while the FSM sits in state s. The select is
    // registered from the next state, so it is already stable on entry.
    function automatic neg_sel_t sel_for_state(input state_t s);
        neg_sel_t v_sel;
        case (s)
            S_NEG_B:  v_sel = SEL_B;
            S_NEG_LO: v_sel = SEL_LO;
            S_NEG_HI: v_sel = SEL_HI;
            default:  v_sel = SEL_A;
        endcase
        return v_sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/signed_seq_mult_ctrl_twos_negate_cin.sv
// ============================================================================
//  Module      : twos_negate_cin
//  Description : Combinational negate-with-carry: {o_cout, o_out} = ~i_in + i_cin.
//                With i_cin=1 this is a two's complement negation and o_cout
//                is set exactly when i_in is zero.
//  Ports       : i_in   [WIDTH-1:0]  operand
//                i_cin               carry in
//                o_out  [WIDTH-1:0]  ~i_in + i_cin (low WIDTH bits)
//                o_cout              carry out of the addition
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module twos_negate_cin #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_out,
    output logic             o_cout
);

    assign {o_cout, o_out} = {1'b0, ~i_in} + {{WIDTH{1'b0}}, i_cin};

endmodule

`default_nettype wire

// File: rtl/signed_seq_mult_ctrl.sv
// ============================================================================
//  Module      : signed_seq_mult_ctrl
//  Description : Sequential signed (two's complement) multiplier controller.
//                One shared negator computes |a|, |b| and then fixes the sign
//                of the 2*WIDTH-bit result; a WIDTH-iteration shift-add runs
//                on the magnitudes in between. Latency is data-independent:
//                done pulses WIDTH+4 rising edges after start is accepted.
//  Ports       : clk                 clock, rising edge
//                rst                 asynchronous reset, active-high
//                start               request, sampled only in IDLE
//                a, b   [WIDTH-1:0]  signed operands, captured on acceptance
//                busy                high in every state except IDLE
//                done                one-cycle pulse, product valid with it
//                product[2W-1:0]     signed product, held until next result
//                ovf                 (only with SIGNED_MULT_OVF_EN) product
//                                    does not fit in WIDTH-bit signed
//  Config      : `define SIGNED_MULT_OVF_EN to add the ovf output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_seq_mult_ctrl
    import signed_seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef SIGNED_MULT_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    neg_sel_t             r_sel;
    logic [WIDTH-1:0]     r_a;        // operand a, then |a|
    logic [WIDTH-1:0]     r_b;        // operand b, then |b| shifted right
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_sgn;
    logic                 r_carry;    // carry out of the low-half negation
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t               w_next_state;
    logic [WIDTH-1:0]     w_neg_in;
    logic                 w_neg_cin;
    logic [WIDTH-1:0]     w_neg_out;
    logic                 w_neg_cout;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic                 w_last_iter;
    logic [WIDTH-1:0]     w_hi_final;
    logic [2*WIDTH-1:0]   w_product_final;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_A;
        end else begin
            r_state <= w_next_state;
            r_sel   <= sel_for_state(w_next_state);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_NEG_A;
            S_NEG_A:  w_next_state = S_NEG_B;
            S_NEG_B:  w_next_state = S_MUL;
            S_MUL:    if (w_last_iter) w_next_state = S_NEG_LO;
            S_NEG_LO: w_next_state = S_NEG_HI;
            S_NEG_HI: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Shared negator input mux. Only the high-half job uses the saved
    // carry; every other job is a plain two's complement negation.
    // ------------------------------------------------------------------
    always_comb begin
        w_neg_in  = r_a;
        w_neg_cin = 1'b1;
        case (r_sel)
            SEL_A:  w_neg_in = r_a;
            SEL_B:  w_neg_in = r_b;
            SEL_LO: w_neg_in = r_lo;
            SEL_HI: begin
                w_neg_in  = r_hi;
                w_neg_cin = r_carry;
            end
            default: w_neg_in = r_a;
        endcase
    end

    twos_negate_cin #(
        .WIDTH (WIDTH)
    ) u_negate (
        .i_in   (w_neg_in),
        .i_cin  (w_neg_cin),
        .o_out  (w_neg_out),
        .o_cout (w_neg_cout)
    );

    // ------------------------------------------------------------------
    // Shift-add step on magnitudes: add |a| when the current multiplier
    // bit is set, then shift {carry, hi, lo} right by one.
    // ------------------------------------------------------------------
    assign w_addend = r_b[0] ? r_a : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

    // The product is loaded on the edge into DONE so it is valid during the
    // done pulse; the high half comes straight from the negator here.
    assign w_hi_final      = r_sgn ? w_neg_out : r_hi;
    assign w_product_final = {w_hi_final, r_lo};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_sgn     <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sgn   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_hi    <= '0;
                        r_lo    <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_NEG_A: begin
                    if (r_a[WIDTH-1]) r_a <= w_neg_out;
                end
                S_NEG_B: begin
                    if (r_b[WIDTH-1]) r_b <= w_neg_out;
                end
                S_MUL: begin
                    r_hi  <= w_sum[WIDTH:1];
                    r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_NEG_LO: begin
                    if (r_sgn) begin
                        r_lo    <= w_neg_out;
                        r_carry <= w_neg_cout;
                    end
                end
                S_NEG_HI: begin
                    r_hi      <= w_hi_final;
                    r_product <= w_product_final;
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

`ifdef SIGNED_MULT_OVF_EN
    // ------------------------------------------------------------------
    // Overflow flag: the top WIDTH+1 bits of a WIDTH-bit-representable
    // product are all copies of the sign bit.
    // ------------------------------------------------------------------
    logic                 r_ovf;
    logic [WIDTH:0]       w_top;
    logic                 w_ovf;

    assign w_top = w_product_final[2*WIDTH-1:WIDTH-1];
    assign w_ovf = ~((&w_top) | ~(|w_top));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_NEG_HI) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_signed_seq_mult_ctrl.sv
// ============================================================================
//  Module      : tb_signed_seq_mult_ctrl
//  Description : Self-checking bench for signed_seq_mult_ctrl. A transaction
//                level model (busy window length, done cycle, signed product
//                from plain arithmetic) is compared against the DUT on every
//                negative edge; directed vectors pin the model with literal
//                products, latency and handshake behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_signed_seq_mult_ctrl;

    localparam int W = 16;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef SIGNED_MULT_OVF_EN
    logic           ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    signed_seq_mult_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef SIGNED_MULT_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[2*W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        longint lim;
        p   = longint'($signed(x)) * longint'($signed(y));
        lim = longint'(1) <<< (W - 1);
        return (p >= lim) || (p < -lim);
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: an accepted start opens a busy window of W+5
    // cycles, done is its last cycle, and the product appears with done.
    // ------------------------------------------------------------------
    int             m_rem     = 0;
    logic [2*W-1:0] m_exp     = '0;
    logic [2*W-1:0] m_prod    = '0;
    logic           m_exp_ovf = 1'b0;
    logic           m_ovf     = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_prod <= '0;
            m_ovf  <= 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem     <= W + 5;
                m_exp     <= ref_mul(a, b);
                m_exp_ovf <= ref_ovf(a, b);
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_prod <= m_exp;
                m_ovf  <= m_exp_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model busy", busy, (m_rem != 0));
            check("model done", done, (m_rem == 1));
            if (m_rem <= 1) begin
                check("model product", product, m_prod);
`ifdef SIGNED_MULT_OVF_EN
                check("model ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_done(output int n);
        n = 0;
        while (n < 40 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] exp_p, input bit chk_ovf,
                          input logic exp_ovf, input string name);
        int n;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check({name, " latency"}, n, 20);
        check({name, " product"}, product, exp_p);
`ifdef SIGNED_MULT_OVF_EN
        if (chk_ovf) check({name, " ovf"}, ovf, exp_ovf);
`endif
        @(negedge clk);
        check({name, " done one cycle"}, done, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int ndone;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
`ifdef SIGNED_MULT_OVF_EN
        check("reset ovf", ovf, 0);
`endif
        #2 rst = 1'b0;
        chk_en = 1'b1;

        run_op(16'd3,    16'd5,    32'h0000000F, 1'b0, 1'b0, "3*5");
        run_op(16'hFFFD, 16'd5,    32'hFFFFFFF1, 1'b0, 1'b0, "-3*5");
        run_op(16'hFFFD, 16'hFFFB, 32'h0000000F, 1'b0, 1'b0, "-3*-5");
        run_op(16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b1, "min*min");
        run_op(16'h7FFF, 16'h8000, 32'hC0008000, 1'b1, 1'b1, "max*min");
        run_op(16'h0000, 16'hFFFF, 32'h00000000, 1'b1, 1'b0, "0*-1");
        run_op(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1, 1'b0, "-1*-1");
        run_op(16'h00FF, 16'h0080, 32'h00007F80, 1'b1, 1'b0, "ff*80");
        run_op(16'h0040, 16'h00FF, 32'h00003FC0, 1'b1, 1'b0, "40*ff");
        run_op(16'hFFFF, 16'h8000, 32'h00008000, 1'b1, 1'b1, "-1*min");
        run_op(16'h0100, 16'h0080, 32'h00008000, 1'b1, 1'b1, "100*80");

        // start raised with new operands mid-operation must be ignored
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ignored start latency", n, 15);
        check("ignored start product", product, 32'h0000000F);
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort product", product, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 16'hFFF0; b = 16'h0011; start = 1'b1;
        ndone = 0;
        repeat (46) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        check("held start done count", ndone, 2);
        wait_done(n);
        check("held start third product", product, 32'hFFFFFEF0);
        @(negedge clk);

        // random sweep, checked by the model
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            run_op(x, y, ref_mul(x, y), 1'b1, ref_ovf(x, y), "random");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
